// File: rtl/dmi_jtag_auth_engine.sv
// dmi_jtag_auth_engine: TCK-domain DMI request engine with key-based unlock.
// It sits between the debug TAP (DR strobes, TDI/TDO) and the DMI CDC
// (request/response handshakes).
// AUTH ops are compared against a loaded key. Consecutive failed attempts
// lead to a lockout that only trst_ni clears.
// Optional macro DMI_AUTH_RELOCK_EN: automatically relock after RelockCycles
// idle cycles while unlocked.
module dmi_jtag_auth_engine #(
    parameter int AddrWidth    = 7,
    parameter int DataWidth    = 32,
    parameter int MaxFails     = 3,
    parameter int RelockCycles = 4096
) (
    input  logic                 clk_i,
    input  logic                 trst_ni,
    input  logic [DataWidth-1:0] key_i,
    input  logic                 key_load_i,
    input  logic                 test_logic_reset_i,
    input  logic                 capture_dr_i,
    input  logic                 shift_dr_i,
    input  logic                 update_dr_i,
    input  logic                 dmi_access_i,
    input  logic                 dtmcs_select_i,
    input  logic                 dmi_reset_i,
    input  logic                 dmi_tdi_i,
    output logic                 dmi_tdo_o,
    output logic [1:0]           error_o,
    output logic                 unlocked_o,
    output logic                 lockout_o,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    output logic [AddrWidth-1:0] req_addr_o,
    output logic [DataWidth-1:0] req_data_o,
    output logic [1:0]           req_op_o,
    input  logic                 resp_valid_i,
    output logic                 resp_ready_o,
    input  logic [DataWidth-1:0] resp_data_i,
    input  logic [1:0]           resp_resp_i
);

    localparam int DRW = AddrWidth + DataWidth + 2;
    localparam logic [7:0] MAX_FAILS = 8'(MaxFails);

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_AUTH  = 2'd3;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_FAILED = 2'd2;
    localparam logic [1:0] ERR_BUSY   = 2'd3;

    typedef enum logic [2:0] {
        Idle,
        Read,
        WaitReadValid,
        Write,
        WaitWriteValid
    } state_e;

    state_e               state_q, state_d;
    logic [DRW-1:0]       dr_q, dr_d;
    logic [AddrWidth-1:0] address_q, address_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [DataWidth-1:0] key_q, key_d;
    logic                 key_valid_q, key_valid_d;
    logic [7:0]           fail_cnt_q, fail_cnt_d;
    logic [1:0]           error_q, error_d;
    logic                 unlocked_q, unlocked_d;
    logic                 lockout_q, lockout_d;

    // DR field views
    logic [AddrWidth-1:0] dr_addr;
    logic [DataWidth-1:0] dr_data;
    logic [1:0]           dr_op;
    assign dr_addr = dr_q[DRW-1 -: AddrWidth];
    assign dr_data = dr_q[DataWidth+1:2];
    assign dr_op   = dr_q[1:0];

    logic busy;
    logic op_failed;
    logic accept;

    // A new DR update is only acted on in Idle with no sticky error pending
    assign accept = update_dr_i && dmi_access_i && (state_q == Idle) && (error_q == ERR_NONE);

    // Busy: an update arrives while a request is in flight, or a capture would read stale read data
    assign busy = (update_dr_i && dmi_access_i && (state_q != Idle)) ||
                  (capture_dr_i && dmi_access_i &&
                   ((state_q == Read) || (state_q == WaitReadValid)));

    // Op decode, request FSM, authentication and key handling
    always_comb begin
        state_d     = state_q;
        address_d   = address_q;
        data_d      = data_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        fail_cnt_d  = fail_cnt_q;
        unlocked_d  = unlocked_q;
        lockout_d   = lockout_q;
        op_failed   = 1'b0;

        if (key_load_i) begin
            key_d       = key_i;
            key_valid_d = 1'b1;
        end

        unique case (state_q)
            Idle: begin
                if (accept) begin
                    address_d = dr_addr;
                    unique case (dr_op)
                        OP_NOP: begin
                            data_d = dr_data;
                        end
                        OP_READ: begin
                            data_d = dr_data;
                            if (unlocked_q) state_d = Read;
                            else            op_failed = 1'b1;
                        end
                        OP_WRITE: begin
                            data_d = dr_data;
                            if (unlocked_q) state_d = Write;
                            else            op_failed = 1'b1;
                        end
                        OP_AUTH: begin
                            // The key never lands in data_q, so it cannot be captured back out
                            if (!lockout_q) begin
                                if (key_valid_q && (dr_data == key_q)) begin
                                    unlocked_d = 1'b1;
                                    fail_cnt_d = 8'd0;
                                end else begin
                                    unlocked_d = 1'b0;
                                    if (fail_cnt_q < MAX_FAILS) begin
                                        fail_cnt_d = fail_cnt_q + 8'd1;
                                    end
                                    if ((fail_cnt_q + 8'd1) >= MAX_FAILS) begin
                                        lockout_d = 1'b1;
                                    end
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            Read: begin
                if (req_ready_i) state_d = WaitReadValid;
            end
            WaitReadValid: begin
                if (resp_valid_i) begin
                    data_d  = resp_data_i;
                    state_d = Idle;
                    if (resp_resp_i != 2'd0) op_failed = 1'b1;
                end
            end
            Write: begin
                if (req_ready_i) state_d = WaitWriteValid;
            end
            WaitWriteValid: begin
                if (resp_valid_i) begin
                    state_d = Idle;
                    if (resp_resp_i != 2'd0) op_failed = 1'b1;
                end
            end
            default: state_d = Idle;
        endcase
    end

    // Sticky error: clear wins, Busy outranks OPFailed and is never downgraded
    always_comb begin
        error_d = error_q;
        if (dmi_reset_i && dtmcs_select_i) begin
            error_d = ERR_NONE;
        end else if (busy) begin
            error_d = ERR_BUSY;
        end else if (op_failed && (error_q != ERR_BUSY)) begin
            error_d = ERR_FAILED;
        end
    end

    // DR shift path: TLR clear, capture of {addr, data, status}, right shift from TDI
    always_comb begin
        dr_d = dr_q;
        if (test_logic_reset_i) begin
            dr_d = '0;
        end else if (capture_dr_i && dmi_access_i) begin
            dr_d = {address_q, data_q, (busy ? ERR_BUSY : error_q)};
        end else if (shift_dr_i && dmi_access_i) begin
            dr_d = {dmi_tdi_i, dr_q[DRW-1:1]};
        end
    end

`ifdef DMI_AUTH_RELOCK_EN
    localparam int RW = $clog2(RelockCycles) + 1;
    localparam logic [RW-1:0] RELOCK_LIMIT = RW'(RelockCycles);

    logic [RW-1:0] relock_cnt_q, relock_cnt_d;
    logic          relock;

    // Idle-time counter; an accepted op restarts it, reaching the limit drops the unlock
    always_comb begin
        relock_cnt_d = relock_cnt_q;
        relock       = 1'b0;
        if (accept) begin
            relock_cnt_d = '0;
        end else if (unlocked_q && (state_q == Idle) && !update_dr_i) begin
            if ((relock_cnt_q + RW'(1)) == RELOCK_LIMIT) begin
                relock       = 1'b1;
                relock_cnt_d = '0;
            end else begin
                relock_cnt_d = relock_cnt_q + RW'(1);
            end
        end else if (!unlocked_q) begin
            relock_cnt_d = '0;
        end
    end

    // Relock counter register
    always_ff @(posedge clk_i or negedge trst_ni) begin
        if (!trst_ni) relock_cnt_q <= '0;
        else          relock_cnt_q <= relock_cnt_d;
    end
`else
    logic relock;
    assign relock = 1'b0;
`endif

    // State registers
    always_ff @(posedge clk_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q     <= Idle;
            dr_q        <= '0;
            address_q   <= '0;
            data_q      <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            fail_cnt_q  <= 8'd0;
            error_q     <= ERR_NONE;
            unlocked_q  <= 1'b0;
            lockout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dr_q        <= dr_d;
            address_q   <= address_d;
            data_q      <= data_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            fail_cnt_q  <= fail_cnt_d;
            error_q     <= error_d;
            unlocked_q  <= unlocked_d && !relock;
            lockout_q   <= lockout_d;
        end
    end

    assign dmi_tdo_o    = dr_q[0];
    assign error_o      = error_q;
    assign unlocked_o   = unlocked_q;
    assign lockout_o    = lockout_q;
    assign req_valid_o  = (state_q == Read) || (state_q == Write);
    assign req_op_o     = (state_q == Read)  ? OP_READ :
                          (state_q == Write) ? OP_WRITE : OP_NOP;
    assign req_addr_o   = address_q;
    assign req_data_o   = data_q;
    assign resp_ready_o = 1'b1;

endmodule

// File: tb/tb_dmi_jtag_auth_engine.sv
// Directed testbench for dmi_jtag_auth_engine (default parameters, MaxFails=3).
// With DMI_AUTH_RELOCK_EN defined the DUT is built with RelockCycles=128,
// which is longer than one full DR scan so that normal traffic keeps the unlock.
module tb_dmi_jtag_auth_engine;

    localparam int AW  = 7;
    localparam int DW  = 32;
    localparam int DRW = AW + DW + 2;
`ifdef DMI_AUTH_RELOCK_EN
    localparam int RELOCK = 128;
`else
    localparam int RELOCK = 4096;
`endif

    logic          clk_i = 1'b0;
    logic          trst_ni = 1'b0;
    logic [DW-1:0] key_i = '0;
    logic          key_load_i = 1'b0;
    logic          test_logic_reset_i = 1'b0;
    logic          capture_dr_i = 1'b0;
    logic          shift_dr_i = 1'b0;
    logic          update_dr_i = 1'b0;
    logic          dmi_access_i = 1'b1;
    logic          dtmcs_select_i = 1'b0;
    logic          dmi_reset_i = 1'b0;
    logic          dmi_tdi_i = 1'b0;
    logic          dmi_tdo_o;
    logic [1:0]    error_o;
    logic          unlocked_o;
    logic          lockout_o;
    logic          req_valid_o;
    logic          req_ready_i = 1'b0;
    logic [AW-1:0] req_addr_o;
    logic [DW-1:0] req_data_o;
    logic [1:0]    req_op_o;
    logic          resp_valid_i = 1'b0;
    logic          resp_ready_o;
    logic [DW-1:0] resp_data_i = '0;
    logic [1:0]    resp_resp_i = 2'd0;

    int tests = 0;
    int fails = 0;

    dmi_jtag_auth_engine #(
        .AddrWidth(AW), .DataWidth(DW), .MaxFails(3), .RelockCycles(RELOCK)
    ) dut (
        .clk_i(clk_i), .trst_ni(trst_ni), .key_i(key_i), .key_load_i(key_load_i),
        .test_logic_reset_i(test_logic_reset_i), .capture_dr_i(capture_dr_i),
        .shift_dr_i(shift_dr_i), .update_dr_i(update_dr_i), .dmi_access_i(dmi_access_i),
        .dtmcs_select_i(dtmcs_select_i), .dmi_reset_i(dmi_reset_i), .dmi_tdi_i(dmi_tdi_i),
        .dmi_tdo_o(dmi_tdo_o), .error_o(error_o), .unlocked_o(unlocked_o),
        .lockout_o(lockout_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_addr_o(req_addr_o), .req_data_o(req_data_o), .req_op_o(req_op_o),
        .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o),
        .resp_data_i(resp_data_i), .resp_resp_i(resp_resp_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] %s observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [DRW-1:0] mk(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                          input logic [1:0] op);
        return {a, d, op};
    endfunction

    // Capture, shift DRW bits (collecting TDO), then one Update-DR cycle
    task automatic scan(input logic [DRW-1:0] din, output logic [DRW-1:0] dout);
        @(negedge clk_i); capture_dr_i = 1'b1;
        @(negedge clk_i); capture_dr_i = 1'b0; shift_dr_i = 1'b1;
        for (int i = 0; i < DRW; i++) begin
            dout[i]   = dmi_tdo_o;
            dmi_tdi_i = din[i];
            @(negedge clk_i);
        end
        shift_dr_i = 1'b0; update_dr_i = 1'b1;
        @(negedge clk_i); update_dr_i = 1'b0;
    endtask

    task automatic pulse_dmireset();
        @(negedge clk_i); dtmcs_select_i = 1'b1; dmi_reset_i = 1'b1;
        @(negedge clk_i); dtmcs_select_i = 1'b0; dmi_reset_i = 1'b0;
    endtask

    task automatic load_key(input logic [DW-1:0] k);
        @(negedge clk_i); key_i = k; key_load_i = 1'b1;
        @(negedge clk_i); key_load_i = 1'b0;
    endtask

    task automatic ready_cycle();
        @(negedge clk_i); req_ready_i = 1'b1;
        @(negedge clk_i); req_ready_i = 1'b0;
    endtask

    task automatic resp_cycle(input logic [DW-1:0] d, input logic [1:0] r);
        @(negedge clk_i); resp_valid_i = 1'b1; resp_data_i = d; resp_resp_i = r;
        @(negedge clk_i); resp_valid_i = 1'b0; resp_resp_i = 2'd0;
    endtask

    logic [DRW-1:0] dout;

    initial begin
        // Reset state
        #12;
        check("rst_unlocked", 64'(unlocked_o), 64'd0);
        check("rst_lockout", 64'(lockout_o), 64'd0);
        check("rst_req_valid", 64'(req_valid_o), 64'd0);
        check("rst_tdo", 64'(dmi_tdo_o), 64'd0);
        check("rst_error", 64'(error_o), 64'd0);
        check("rst_resp_ready", 64'(resp_ready_o), 64'd1);
        @(negedge clk_i); trst_ni = 1'b1;

        // Locked READ is dropped with OPFailed
        load_key(32'hDEADC0DE);
        scan(mk(7'h11, 32'h0, 2'd1), dout);
        check("locked_read_valid", 64'(req_valid_o), 64'd0);
        check("locked_read_err", 64'(error_o), 64'd2);
        scan(mk(7'h0, 32'h0, 2'd0), dout);
        check("locked_read_capture", 64'(dout), 64'(mk(7'h11, 32'h0, 2'd2)));
        pulse_dmireset();
        check("dmireset_clear", 64'(error_o), 64'd0);

        // Correct AUTH unlocks, then WRITE
        scan(mk(7'h0, 32'hDEADC0DE, 2'd3), dout);
        check("auth_unlock", 64'(unlocked_o), 64'd1);
        scan(mk(7'h10, 32'h1, 2'd2), dout);
        check("wr_valid", 64'(req_valid_o), 64'd1);
        check("wr_op", 64'(req_op_o), 64'd2);
        check("wr_addr", 64'(req_addr_o), 64'h10);
        check("wr_data", 64'(req_data_o), 64'h1);
        @(negedge clk_i);
        check("wr_valid_held", 64'(req_valid_o), 64'd1);
        ready_cycle();
        check("wr_valid_drop", 64'(req_valid_o), 64'd0);
        resp_cycle(32'h0, 2'd0);
        scan(mk(7'h0, 32'h0, 2'd0), dout);
        check("wr_capture", 64'(dout), 64'(mk(7'h10, 32'h1, 2'd0)));

        // READ with response data captured back out
        scan(mk(7'h04, 32'h0, 2'd1), dout);
        check("rd_valid", 64'(req_valid_o), 64'd1);
        check("rd_op", 64'(req_op_o), 64'd1);
        check("rd_addr", 64'(req_addr_o), 64'h04);
        ready_cycle();
        resp_cycle(32'hA5A5A5A5, 2'd0);
        scan(mk(7'h0, 32'h0, 2'd0), dout);
        check("rd_capture", 64'(dout), 64'(mk(7'h04, 32'hA5A5A5A5, 2'd0)));
        check("rd_err", 64'(error_o), 64'd0);

        // Busy: capture and update while waiting for read data
        scan(mk(7'h05, 32'h0, 2'd1), dout);
        ready_cycle();
        scan(mk(7'h0, 32'h0, 2'd0), dout);
        check("busy_capture", 64'(dout), 64'(mk(7'h05, 32'h0, 2'd3)));
        check("busy_err", 64'(error_o), 64'd3);
        resp_cycle(32'h12345678, 2'd0);
        check("busy_err_sticky", 64'(error_o), 64'd3);
        scan(mk(7'h01, 32'h7, 2'd2), dout);
        check("busy_ignored_valid", 64'(req_valid_o), 64'd0);
        check("busy_ignored_capture", 64'(dout), 64'(mk(7'h05, 32'h12345678, 2'd3)));
        pulse_dmireset();
        check("busy_clear", 64'(error_o), 64'd0);

        // Failing response reports OPFailed
        scan(mk(7'h06, 32'h0, 2'd1), dout);
        ready_cycle();
        resp_cycle(32'hFFFF0000, 2'd2);
        check("resp_fail_err", 64'(error_o), 64'd2);
        pulse_dmireset();

        // Three failed AUTHs lock out
        scan(mk(7'h0, 32'h0, 2'd3), dout);
        check("fail1_unlocked", 64'(unlocked_o), 64'd0);
        check("fail1_lockout", 64'(lockout_o), 64'd0);
        scan(mk(7'h0, 32'h0, 2'd3), dout);
        check("fail2_lockout", 64'(lockout_o), 64'd0);
        scan(mk(7'h0, 32'h0, 2'd3), dout);
        check("fail3_lockout", 64'(lockout_o), 64'd1);
        scan(mk(7'h0, 32'hDEADC0DE, 2'd3), dout);
        check("locked_auth_unlocked", 64'(unlocked_o), 64'd0);
        check("locked_auth_err", 64'(error_o), 64'd0);
        @(negedge clk_i); trst_ni = 1'b0;
        @(negedge clk_i);
        check("trst_lockout", 64'(lockout_o), 64'd0);
        trst_ni = 1'b1;
        load_key(32'hDEADC0DE);
        scan(mk(7'h0, 32'hDEADC0DE, 2'd3), dout);
        check("reauth_unlock", 64'(unlocked_o), 64'd1);
        load_key(32'h00000001);
        check("keyload_keeps_unlock", 64'(unlocked_o), 64'd1);

        // Idle persistence / auto-relock
        scan(mk(7'h0, 32'h1, 2'd3), dout);
`ifdef DMI_AUTH_RELOCK_EN
        repeat (RELOCK - 1) @(negedge clk_i);
        check("relock_before", 64'(unlocked_o), 64'd1);
        @(negedge clk_i);
        check("relock_after", 64'(unlocked_o), 64'd0);
        scan(mk(7'h0, 32'h1, 2'd3), dout);
        repeat (RELOCK - 1) @(negedge clk_i);
        update_dr_i = 1'b1;
        @(negedge clk_i); update_dr_i = 1'b0;
        repeat (RELOCK - 1) @(negedge clk_i);
        check("relock_restart_held", 64'(unlocked_o), 64'd1);
        @(negedge clk_i);
        check("relock_restart_fall", 64'(unlocked_o), 64'd0);
`else
        repeat (300) @(negedge clk_i);
        check("unlock_persists", 64'(unlocked_o), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
